// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key-schedule sequencer: holds the 56-bit C/D state and streams
// the 16 round subkeys, one per handshake, in encrypt or decrypt order.
module des_key_sched_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] rk_out,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [3:0]  rk_step,
  output logic        rk_last,
  output logic        busy
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned RK_W   = 48;
  localparam int unsigned STEP_W = 4;

  // Bit numbers are FIPS 1-based positions; position 1 is the MSB.
  localparam int unsigned PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [RK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CD_W-1:0]     cd_q, cd_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                dir_q, dir_d;

  logic                run_c;
  logic [CD_W-1:0]     pc1_key_c;
  logic [4:0]          enc_round_c;
  logic [4:0]          dec_round_c;
  logic                unused_parity;

  // PC-1: 64-bit key to 56-bit C/D, dropping the parity bits.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      r[int'(CD_W) - 1 - i] = key[int'(KEY_W) - int'(PC1_TBL[i])];
    end
    return r;
  endfunction

  // PC-2: 56-bit C/D to 48-bit subkey.
  function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [RK_W-1:0] r;
    r = '0;
    for (int j = 0; j < int'(RK_W); j++) begin
      r[int'(RK_W) - 1 - j] = cd[int'(CD_W) - int'(PC2_TBL[j])];
    end
    return r;
  endfunction

  // Rotate C and D left independently by one or two places.
  function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] cd, input logic two);
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = cd[CD_W-1:HALF_W];
    d = cd[HALF_W-1:0];
    if (two) begin
      return {c[HALF_W-3:0], c[HALF_W-1:HALF_W-2], d[HALF_W-3:0], d[HALF_W-1:HALF_W-2]};
    end
    return {c[HALF_W-2:0], c[HALF_W-1], d[HALF_W-2:0], d[HALF_W-1]};
  endfunction

  // Rotate C and D right independently by one or two places.
  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] cd, input logic two);
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = cd[CD_W-1:HALF_W];
    d = cd[HALF_W-1:0];
    if (two) begin
      return {c[1:0], c[HALF_W-1:2], d[1:0], d[HALF_W-1:2]};
    end
    return {c[0], c[HALF_W-1:1], d[0], d[HALF_W-1:1]};
  endfunction

  // Shift table for rounds 1..16: single shifts at rounds 1, 2, 9 and 16.
  function automatic logic shift_is_two(input logic [4:0] round);
    return !((round == 5'd1) || (round == 5'd2) || (round == 5'd9) || (round == 5'd16));
  endfunction

  assign pc1_key_c   = pc1(key_in);
  assign enc_round_c = 5'(step_q) + 5'd2;
  assign dec_round_c = 5'd16 - 5'(step_q);

  // Parity bits of the key never reach the schedule.
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // State, C/D, step and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cd_q    <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state: key load in IDLE, C/D advance on each consumed subkey, abort wins.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    step_d  = step_q;
    dir_d   = dir_q;
    if (abort) begin
      state_d = S_IDLE;
      cd_d    = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            dir_d   = decrypt;
            step_d  = '0;
            cd_d    = decrypt ? pc1_key_c : rotl(pc1_key_c, 1'b0);
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (rk_ready) begin
            if (step_q == 4'd15) begin
              state_d = S_IDLE;
              step_d  = '0;
            end else begin
              step_d = step_q + 4'd1;
              cd_d   = dir_q ? rotr(cd_q, shift_is_two(dec_round_c))
                             : rotl(cd_q, shift_is_two(enc_round_c));
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from registered state; everything held at zero while rst is high.
  assign run_c     = (state_q == S_RUN) && !rst;
  assign key_ready = (state_q == S_IDLE) && !rst;
  assign rk_valid  = run_c;
  assign busy      = run_c;
  assign rk_out    = run_c ? pc2(cd_q) : '0;
  assign rk_step   = run_c ? step_q : '0;
  assign rk_last   = run_c && (step_q == 4'd15);

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl with an independent FIPS 46-3 subkey model.
module tb_des_key_sched_ctrl;

  logic        clk;
  logic        rst;
  logic        abort;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] rk_out;
  logic        rk_valid;
  logic        rk_ready;
  logic [3:0]  rk_step;
  logic        rk_last;
  logic        busy;

  int n_cmp;
  int n_bad;

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2     = 64'h0E329232EA6D0D73;
  localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_step   (rk_step),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subkey K_n from FIPS tables: cumulative left shift of C0/D0, then PC-2.
  function automatic logic [47:0] ref_key(input logic [63:0] key, input int n);
    logic [56:1] cd0;
    logic [56:1] cdn;
    logic [47:0] k;
    int t;
    t = 0;
    for (int i = 1; i <= n; i++) t += SHIFTS[i-1];
    for (int i = 1; i <= 56; i++) cd0[i] = key[64 - PC1[i-1]];
    for (int i = 1; i <= 28; i++) begin
      cdn[i]      = cd0[((i - 1 + t) % 28) + 1];
      cdn[i + 28] = cd0[((i - 1 + t) % 28) + 29];
    end
    for (int j = 1; j <= 48; j++) k[48 - j] = cdn[PC2[j-1]];
    return k;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; abort = 1'b0; key_in = KEY2; decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({key_ready, rk_valid, busy, rk_last, rk_step, rk_out} !== 56'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {key_ready, rk_valid, busy, rk_last, rk_step, rk_out});
    end
    key_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({key_ready, rk_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release: got rdy/vld/busy=%b expected 100", {key_ready, rk_valid, busy});
    end
    tick;
  endtask

  task automatic test_fips(input logic dec);
    logic [47:0] exp;
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fips_ready_before: got %b expected 1", key_ready);
    end
    key_in = FIPS_KEY; decrypt = dec; key_valid = 1'b1; rk_ready = 1'b1;
    tick;
    key_valid = 1'b0; key_in = '0; decrypt = 1'b0;
    for (int j = 0; j < 16; j++) begin
      exp = ref_key(FIPS_KEY, dec ? 16 - j : j + 1);
      n_cmp++;
      if ({rk_valid, busy, key_ready, rk_last, rk_step, rk_out} !==
          {1'b1, 1'b1, 1'b0, (j == 15), 4'(j), exp}) begin
        n_bad++;
        $display("FAIL fips_seq dec=%0d step=%0d: got v=%b b=%b r=%b l=%b s=%0d k=%h expected k=%h",
                 dec, j, rk_valid, busy, key_ready, rk_last, rk_step, rk_out, exp);
      end
      if (j == 0) begin
        n_cmp++;
        if (rk_out !== (dec ? FIPS_K16 : FIPS_K1)) begin
          n_bad++;
          $display("FAIL fips_first dec=%0d: got %h expected %h", dec, rk_out, dec ? FIPS_K16 : FIPS_K1);
        end
      end
      if (j == 15) begin
        n_cmp++;
        if (rk_out !== (dec ? FIPS_K1 : FIPS_K16)) begin
          n_bad++;
          $display("FAIL fips_last dec=%0d: got %h expected %h", dec, rk_out, dec ? FIPS_K1 : FIPS_K16);
        end
      end
      if ((j == 1 && !dec) || (j == 14 && dec)) begin
        n_cmp++;
        if (rk_out !== FIPS_K2) begin
          n_bad++;
          $display("FAIL fips_k2 dec=%0d: got %h expected %h", dec, rk_out, FIPS_K2);
        end
      end
      tick;
    end
    n_cmp++;
    if ({key_ready, rk_valid, busy, rk_out} !== {1'b1, 1'b0, 1'b0, 48'd0}) begin
      n_bad++;
      $display("FAIL fips_done dec=%0d: got rdy=%b vld=%b busy=%b k=%h expected 1 0 0 0",
               dec, key_ready, rk_valid, busy, rk_out);
    end
  endtask

  task automatic test_ignore_key_valid;
    logic [47:0] exp;
    logic dsel;
    key_in = FIPS_KEY; decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
    tick;
    key_in = KEY2;
    for (int j = 0; j < 16; j++) begin
      exp = ref_key(FIPS_KEY, j + 1);
      n_cmp++;
      if ({rk_valid, rk_step, rk_out} !== {1'b1, 4'(j), exp}) begin
        n_bad++;
        $display("FAIL ignore_kv step=%0d: got v=%b s=%0d k=%h expected k=%h",
                 j, rk_valid, rk_step, rk_out, exp);
      end
      decrypt = ~decrypt;
      tick;
    end
    n_cmp++;
    if ({key_ready, rk_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL ignore_kv_idle: got rdy/vld=%b expected 10", {key_ready, rk_valid});
    end
    dsel = decrypt;
    tick;
    key_valid = 1'b0;
    exp = ref_key(KEY2, dsel ? 16 : 1);
    n_cmp++;
    if ({rk_valid, rk_step, rk_out} !== {1'b1, 4'd0, exp}) begin
      n_bad++;
      $display("FAIL back_to_back_start: got v=%b s=%0d k=%h expected k=%h", rk_valid, rk_step, rk_out, exp);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_abort;
    key_in = FIPS_KEY; decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
    tick;
    key_valid = 1'b0;
    repeat (7) tick;
    n_cmp++;
    if ({rk_valid, rk_step} !== {1'b1, 4'd7}) begin
      n_bad++;
      $display("FAIL abort_at_step7: got v=%b s=%0d expected 1 7", rk_valid, rk_step);
    end
    abort = 1'b1; rk_ready = 1'b1;
    tick;
    abort = 1'b0;
    n_cmp++;
    if ({key_ready, rk_valid, busy, rk_step, rk_out} !== {1'b1, 1'b0, 1'b0, 4'd0, 48'd0}) begin
      n_bad++;
      $display("FAIL abort_idle: got rdy=%b v=%b b=%b s=%0d k=%h expected 1 0 0 0 0",
               key_ready, rk_valid, busy, rk_step, rk_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (rk_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_resume cyc=%0d: got v=%b expected 0", i, rk_valid);
      end
    end
    key_valid = 1'b1; abort = 1'b1;
    tick;
    abort = 1'b0; key_valid = 1'b0;
    n_cmp++;
    if ({key_ready, rk_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_beats_accept: got rdy/vld=%b expected 10", {key_ready, rk_valid});
    end
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    n_cmp++;
    if ({rk_valid, rk_step, rk_out} !== {1'b1, 4'd0, FIPS_K1}) begin
      n_bad++;
      $display("FAIL abort_restart_k1: got v=%b s=%0d k=%h expected 1 0 %h", rk_valid, rk_step, rk_out, FIPS_K1);
    end
    tick;
    n_cmp++;
    if ({rk_valid, rk_step, rk_out} !== {1'b1, 4'd1, FIPS_K2}) begin
      n_bad++;
      $display("FAIL abort_restart_k2: got v=%b s=%0d k=%h expected 1 1 %h", rk_valid, rk_step, rk_out, FIPS_K2);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_rst_midjob;
    key_in = FIPS_KEY; decrypt = 1'b1; key_valid = 1'b1; rk_ready = 1'b1;
    tick;
    key_valid = 1'b0;
    repeat (4) tick;
    n_cmp++;
    if ({rk_valid, rk_step} !== {1'b1, 4'd4}) begin
      n_bad++;
      $display("FAIL rst_at_step4: got v=%b s=%0d expected 1 4", rk_valid, rk_step);
    end
    rst = 1'b1; key_valid = 1'b1; key_in = KEY2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({key_ready, rk_valid, busy, rk_last, rk_step, rk_out} !== 56'd0) begin
        n_bad++;
        $display("FAIL rst_outputs cyc=%0d: got %h expected 0", i,
                 {key_ready, rk_valid, busy, rk_last, rk_step, rk_out});
      end
      tick;
    end
    rst = 1'b0; key_valid = 1'b0;
    #1;
    n_cmp++;
    if ({key_ready, rk_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rst_release: got rdy/vld=%b expected 10", {key_ready, rk_valid});
    end
    tick;
    n_cmp++;
    if ({key_ready, rk_valid, rk_out} !== {1'b1, 1'b0, 48'd0}) begin
      n_bad++;
      $display("FAIL rst_no_resume: got rdy=%b v=%b k=%h expected 1 0 0", key_ready, rk_valid, rk_out);
    end
  endtask

  task automatic test_random_stall;
    logic [63:0] k;
    logic        d;
    logic [47:0] ks [16];
    int          fires;
    int          budget;
    for (int job = 0; job < 200; job++) begin
      k = {$urandom, $urandom};
      d = 1'($urandom);
      for (int j = 0; j < 16; j++) ks[j] = ref_key(k, d ? 16 - j : j + 1);
      key_in = k; decrypt = d; key_valid = 1'b1; rk_ready = 1'($urandom);
      tick;
      key_valid = 1'b0;
      fires = 0;
      budget = 0;
      while (fires < 16 && budget < 200) begin
        n_cmp++;
        if ({rk_valid, rk_last, rk_step, rk_out} !== {1'b1, (fires == 15), 4'(fires), ks[fires]}) begin
          n_bad++;
          $display("FAIL rand_seq job=%0d fire=%0d: got v=%b l=%b s=%0d k=%h expected k=%h",
                   job, fires, rk_valid, rk_last, rk_step, rk_out, ks[fires]);
        end
        rk_ready = 1'($urandom);
        if (rk_ready && rk_valid) fires++;
        budget++;
        tick;
      end
      n_cmp++;
      if (fires != 16) begin
        n_bad++;
        $display("FAIL rand_timeout job=%0d: got %0d fires expected 16", job, fires);
      end
      n_cmp++;
      if ({rk_valid, key_ready} !== 2'b01) begin
        n_bad++;
        $display("FAIL rand_job_end job=%0d: got vld/rdy=%b expected 01", job, {rk_valid, key_ready});
      end
    end
    rk_ready = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; abort = 1'b0; key_in = '0; decrypt = 1'b0; key_valid = 1'b0; rk_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_fips(1'b0);
    test_fips(1'b1);
    test_ignore_key_valid;
    test_abort;
    test_rst_midjob;
    test_random_stall;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
